// File: rtl/mul16_share_pkg.sv
// Shared types and sizing for the time-shared 16x16 multiplier scheduler.
package mul16_share_pkg;

   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned ID_W_DEF    = 2;
   localparam int unsigned ID_MAX_W    = 3;
   localparam int unsigned OP_W        = 16;
   localparam int unsigned PROD_W      = 32;

   typedef struct packed {
      logic [OP_W-1:0]     a;
      logic [OP_W-1:0]     b;
      logic [ID_MAX_W-1:0] id;
   } op_t;

endpackage

// File: rtl/mul16_evo312.sv
// Approximate 16x16 unsigned multiplier: product columns 0..7 are OR-compressed
// (carries dropped), columns 8 and up are summed exactly.
module mul16_evo312 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] y
);

   logic [31:0] row;
   logic [31:0] lo_or;
   logic [31:0] hi_sum;

   always_comb begin
      row    = '0;
      lo_or  = '0;
      hi_sum = '0;
      for (int unsigned j = 0; j < 16; j++) begin
         row    = {16'd0, a & {16{b[j]}}} << j;
         lo_or  = lo_or | (row & 32'h0000_00FF);
         hi_sum = hi_sum + (row & 32'hFFFF_FF00);
      end
      y = hi_sum | lo_or;
   end

endmodule

// File: rtl/mul16_share_sched_rr_arbiter.sv
// Round-robin arbiter: wrap-around priority search from ptr, one-hot grant,
// pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_vld
);

   logic [ID_W-1:0] ptr;

   always_comb begin
      int unsigned     idx;
      logic [ID_W-1:0] sel;
      idx       = 0;
      sel       = '0;
      grant     = '0;
      grant_id  = '0;
      grant_vld = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = ID_W'(idx);
         if (!grant_vld && req[sel]) begin
            grant_vld  = 1'b1;
            grant[sel] = 1'b1;
            grant_id   = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/mul16_share_sched.sv
// Shares one mul16_evo312 among NUM_REQ valid/ready requesters; operands and
// product are registered so the multiplier sits alone between two flop stages.
module mul16_share_sched
   import mul16_share_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ID_W    = ID_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*OP_W-1:0] req_a,
   input  logic [NUM_REQ*OP_W-1:0] req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [PROD_W-1:0]       rsp_c,
   output logic                    busy,
   output logic [31:0]             ops_done
);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               grant_vld;
   logic               s1_vld;
   op_t                op;
   logic [PROD_W-1:0]  prod;
   logic               adv1;
   logic               adv2;
   logic               accept;

   // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
   assign adv2      = !rsp_valid || rsp_ready;
   assign adv1      = !s1_vld || adv2;
   assign accept    = grant_vld && adv1 && rst_n;
   assign req_ready = grant & {NUM_REQ{adv1 && rst_n}};
   assign busy      = s1_vld || rsp_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .accept    (accept),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_vld (grant_vld)
   );

   mul16_evo312 u_mul (
      .a (op.a),
      .b (op.b),
      .y (prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         op     <= '0;
      end else if (adv1) begin
         s1_vld <= accept;
         if (accept) begin
            op.a  <= req_a[OP_W*grant_id +: OP_W];
            op.b  <= req_b[OP_W*grant_id +: OP_W];
            op.id <= ID_MAX_W'(grant_id);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_c     <= '0;
         rsp_id    <= '0;
         ops_done  <= '0;
      end else begin
         if (adv2) begin
            rsp_valid <= s1_vld;
            if (s1_vld) begin
               rsp_c  <= prod;
               rsp_id <= op.id[ID_W-1:0];
            end
         end
         if (rsp_valid && rsp_ready) ops_done <= ops_done + 32'd1;
      end
   end

endmodule
